// File: rtl/hazard_stall_ctrl.sv
// Load-use and data-memory stall control for the ID/EX pipeline boundary.
// Control outputs are combinational; counters, wait FSM and timeout flag are registered.
module hazard_stall_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs_a,
  input  logic [4:0]       id_rt_a,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_load,
  input  logic [4:0]       ex_dst_a,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] load_use_count,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            mem_stall;
  logic            lu_hit;

  assign mem_stall = mem_req & ~mem_ready;
  assign lu_hit    = ex_load & (ex_dst_a != 5'd0) &
                     ((id_uses_rs & (id_rs_a == ex_dst_a)) |
                      (id_uses_rt & (id_rt_a == ex_dst_a)));

  // Memory stall freezes everything and defers any load-use bubble.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_bubble  = 1'b0;
    idex_hold    = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    if (!reset) begin
      if (mem_stall) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_hold    = 1'b1;
        exmem_hold   = 1'b1;
        memwb_bubble = 1'b1;
      end else if (lu_hit) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // Wait timer, sticky timeout flag and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_RUN;
      wait_cnt       <= '0;
      mem_timeout    <= 1'b0;
      load_use_count <= '0;
      stall_cycles   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        ST_WAIT: begin
          if (mem_ready || !mem_req) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt != WC_W'(MEM_TIMEOUT)) begin
            wait_cnt <= wait_cnt + WC_W'(1);
            if (wait_cnt == WC_W'(MEM_TIMEOUT - 1)) mem_timeout <= 1'b1;
          end
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase

      if (lu_hit && !mem_stall && (load_use_count != '1))
        load_use_count <= load_use_count + CNT_W'(1);
      if ((mem_stall || lu_hit) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
